alu_issue: RTL and testbench

Two-stage issue/writeback front end that drives the 32-bit ALU. It accepts a decoded-operand instruction packet over a valid/ready handshake and translates the MIPS opcode/funct into the ALU's 3-bit `op`. It presents registered operands to an external ALU, then captures `z`/`zero` into a result register with writeback and branch metadata. It sits between register-file read and writeback, so the ALU stays purely combinational.

---
 rtl/alu_issue_if.sv | 36 +++
 rtl/alu_issue.sv | 191 +++++++++++++++++++
 tb/tb_alu_issue.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Handshake, operand and ALU-side signals of the alu_issue front end.
// The DUT uses the slave modport; the environment drives through master.
interface alu_issue_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_instr;
  logic [W-1:0] in_rs_val;
  logic [W-1:0] in_rt_val;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_z;
  logic         alu_zero;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_wr_en;
  logic [4:0]   out_wr_reg;
  logic         out_branch;
  logic         out_taken;
  logic         out_illegal;

  modport slave (
    input  in_valid, in_instr, in_rs_val, in_rt_val, alu_z, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_result,
           out_wr_en, out_wr_reg, out_branch, out_taken, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_rs_val, in_rt_val, alu_z, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result,
           out_wr_en, out_wr_reg, out_branch, out_taken, out_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// Two-stage issue/writeback front end for a combinational 32-bit ALU:
// stage 1 decodes and presents registered operands, stage 2 captures the result.
module alu_issue #(
  parameter int W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  logic [5:0]   w_opcode;
  logic [5:0]   w_funct;
  logic [4:0]   w_rt;
  logic [4:0]   w_rd;
  logic [15:0]  w_imm;
  logic [W-1:0] w_sext;
  logic [W-1:0] w_zext;

  assign w_opcode = bus.in_instr[31:26];
  assign w_rt     = bus.in_instr[20:16];
  assign w_rd     = bus.in_instr[15:11];
  assign w_funct  = bus.in_instr[5:0];
  assign w_imm    = bus.in_instr[15:0];
  assign w_sext   = {{(W-16){w_imm[15]}}, w_imm};
  assign w_zext   = {{(W-16){1'b0}}, w_imm};

  alu_op_e      w_op;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [4:0]   w_dst;
  logic         w_wr;
  logic         w_br;
  logic         w_bne;
  logic         w_ill;

  always_comb begin
    w_op  = OP_AND;
    w_a   = '0;
    w_b   = '0;
    w_dst = '0;
    w_wr  = 1'b0;
    w_br  = 1'b0;
    w_bne = 1'b0;
    w_ill = 1'b0;
    unique case (w_opcode)
      6'h00: begin
        w_a   = bus.in_rs_val;
        w_b   = bus.in_rt_val;
        w_dst = w_rd;
        w_wr  = 1'b1;
        case (w_funct)
          6'h20:   w_op = OP_ADD;
          6'h22:   w_op = OP_SUB;
          6'h24:   w_op = OP_AND;
          6'h25:   w_op = OP_OR;
          6'h2A:   w_op = OP_SLT;
          default: begin
            w_a   = '0;
            w_b   = '0;
            w_dst = '0;
            w_wr  = 1'b0;
            w_ill = 1'b1;
          end
        endcase
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        w_a   = bus.in_rs_val;
        w_dst = w_rt;
        w_wr  = 1'b1;
        case (w_opcode)
          6'h08:   begin w_op = OP_ADD; w_b = w_sext; end
          6'h0A:   begin w_op = OP_SLT; w_b = w_sext; end
          6'h0C:   begin w_op = OP_AND; w_b = w_zext; end
          default: begin w_op = OP_OR;  w_b = w_zext; end
        endcase
      end
      6'h04, 6'h05: begin
        w_op  = OP_SUB;
        w_a   = bus.in_rs_val;
        w_b   = bus.in_rt_val;
        w_br  = 1'b1;
        w_bne = w_opcode[0];
      end
      default: w_ill = 1'b1;
    endcase
  end

  // r_run keeps in_ready low while reset is held and for the first edge after it
  logic         r_run;
  logic         r_v1;
  logic [W-1:0] r_alu_a;
  logic [W-1:0] r_alu_b;
  alu_op_e      r_alu_op;
  logic         r_wr_en1;
  logic [4:0]   r_wr_reg1;
  logic         r_br1;
  logic         r_bne1;
  logic         r_ill1;

  logic         r_out_valid;
  logic [W-1:0] r_result;
  logic         r_wr_en2;
  logic [4:0]   r_wr_reg2;
  logic         r_br2;
  logic         r_taken2;
  logic         r_ill2;

  logic w_s2_ready;
  logic w_in_ready;
  logic w_in_fire;
  logic w_s2_load;

  assign w_s2_ready = !r_out_valid || bus.out_ready;
  assign w_in_ready = r_run && (!r_v1 || w_s2_ready);
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_s2_load  = r_v1 && w_s2_ready;

  // Only the valid bit drops when stage 1 drains, so alu_a/b/op never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_v1      <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= OP_AND;
      r_wr_en1  <= 1'b0;
      r_wr_reg1 <= '0;
      r_br1     <= 1'b0;
      r_bne1    <= 1'b0;
      r_ill1    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_in_fire) begin
        r_v1      <= 1'b1;
        r_alu_a   <= w_a;
        r_alu_b   <= w_b;
        r_alu_op  <= w_op;
        r_wr_en1  <= w_wr && (w_dst != '0);
        r_wr_reg1 <= w_dst;
        r_br1     <= w_br;
        r_bne1    <= w_bne;
        r_ill1    <= w_ill;
      end else if (w_s2_ready) begin
        r_v1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_wr_en2    <= 1'b0;
      r_wr_reg2   <= '0;
      r_br2       <= 1'b0;
      r_taken2    <= 1'b0;
      r_ill2      <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_result    <= bus.alu_z;
      r_wr_en2    <= r_wr_en1;
      r_wr_reg2   <= r_wr_reg1;
      r_br2       <= r_br1;
      r_taken2    <= r_br1 && (bus.alu_zero ^ r_bne1);
      r_ill2      <= r_ill1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_op      = r_alu_op;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_result  = r_result;
  assign bus.out_wr_en   = r_wr_en2;
  assign bus.out_wr_reg  = r_wr_reg2;
  assign bus.out_branch  = r_br2;
  assign bus.out_taken   = r_taken2;
  assign bus.out_illegal = r_ill2;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a behavioural ALU closes the loop and an
// instruction-level reference model predicts every writeback packet.
module tb_alu_issue;

  typedef struct packed {
    logic [31:0] result;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic        br;
    logic        taken;
    logic        ill;
  } pkt_t;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_pass;
  pkt_t sb[$];

  alu_issue_if #(.W(32)) bus();

  alu_issue #(.W(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (bus.alu_op)
      3'b000:  bus.alu_z = bus.alu_a & bus.alu_b;
      3'b001:  bus.alu_z = bus.alu_a | bus.alu_b;
      3'b010:  bus.alu_z = bus.alu_a + bus.alu_b;
      3'b110:  bus.alu_z = bus.alu_a - bus.alu_b;
      3'b111:  bus.alu_z = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      default: bus.alu_z = '0;
    endcase
    bus.alu_zero = (bus.alu_z == '0);
  end

  function automatic pkt_t ref_pkt(input logic [31:0] ins, input logic [31:0] rs,
                                   input logic [31:0] rt);
    pkt_t p;
    logic [31:0] sx, zx;
    logic [4:0] dst;
    logic wr;
    p   = '0;
    dst = '0;
    wr  = 1'b0;
    sx  = {{16{ins[15]}}, ins[15:0]};
    zx  = {16'h0, ins[15:0]};
    case (ins[31:26])
      6'h00: begin
        dst = ins[15:11];
        wr  = 1'b1;
        case (ins[5:0])
          6'h20: p.result = rs + rt;
          6'h22: p.result = rs - rt;
          6'h24: p.result = rs & rt;
          6'h25: p.result = rs | rt;
          6'h2A: p.result = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
          default: begin p.ill = 1'b1; wr = 1'b0; dst = '0; end
        endcase
      end
      6'h08: begin p.result = rs + sx; dst = ins[20:16]; wr = 1'b1; end
      6'h0A: begin p.result = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0; dst = ins[20:16]; wr = 1'b1; end
      6'h0C: begin p.result = rs & zx; dst = ins[20:16]; wr = 1'b1; end
      6'h0D: begin p.result = rs | zx; dst = ins[20:16]; wr = 1'b1; end
      6'h04: begin p.result = rs - rt; p.br = 1'b1; p.taken = (rs == rt); end
      6'h05: begin p.result = rs - rt; p.br = 1'b1; p.taken = (rs != rt); end
      default: p.ill = 1'b1;
    endcase
    p.wr_en  = wr && (dst != 5'd0);
    p.wr_reg = dst;
    return p;
  endfunction

  // One cycle: sample at the current falling edge, log acceptance, advance a clock.
  task automatic step(output bit acc, output bit fired, output pkt_t got);
    #1;
    acc   = bus.in_valid && bus.in_ready;
    fired = bus.out_valid && bus.out_ready;
    got   = {bus.out_result, bus.out_wr_en, bus.out_wr_reg,
             bus.out_branch, bus.out_taken, bus.out_illegal};
    if (acc) sb.push_back(ref_pkt(bus.in_instr, bus.in_rs_val, bus.in_rt_val));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h012A4020;
    bus.in_rs_val = 32'd1;
    bus.in_rt_val = 32'd2;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++;
    if (bus.alu_op !== 3'b000) $display("FAIL reset_alu_op got=%b exp=000", bus.alu_op); else n_pass++;
    n_checks++;
    if (bus.out_result !== 32'h0) $display("FAIL reset_out_result got=%h exp=0", bus.out_result); else n_pass++;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL release_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_decode();
    logic [31:0] t_ins[14] = '{32'h012A4020, 32'h2883FFFF, 32'h3083FFFF, 32'h10220010,
                               32'h14220010, 32'hFC221234, 32'h00C72822, 32'h00641025,
                               32'h0064102A, 32'h00220020, 32'h2109FFFD, 32'h35098000,
                               32'h00000027, 32'h14220010};
    logic [31:0] t_rs[14]  = '{32'd7, 32'hFFFFFFFE, 32'hFFFF1234, 32'd9, 32'd9, 32'd9, 32'd3,
                               32'h0F0, 32'hFFFFFFFB, 32'd5, 32'd10, 32'h00010001, 32'd1, 32'd4};
    logic [31:0] t_rt[14]  = '{32'd5, 32'd0, 32'd0, 32'd9, 32'd9, 32'd9, 32'd10,
                               32'h00F, 32'd2, 32'd6, 32'd0, 32'd0, 32'd2, 32'd9};
    logic [31:0] t_res[14] = '{32'd12, 32'd1, 32'h1234, 32'd0, 32'd0, 32'd0, 32'hFFFFFFF9,
                               32'hFF, 32'd1, 32'd11, 32'd7, 32'h18001, 32'd0, 32'hFFFFFFFB};
    logic [2:0]  t_op[14]  = '{3'b010, 3'b111, 3'b000, 3'b110, 3'b110, 3'b000, 3'b110,
                               3'b001, 3'b111, 3'b010, 3'b010, 3'b001, 3'b000, 3'b110};
    bit acc, fired;
    pkt_t got, e;
    int unsigned idx, outs, stalls, first_fire;
    idx = 0; outs = 0; stalls = 0; first_fire = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = t_ins[0]; bus.in_rs_val = t_rs[0]; bus.in_rt_val = t_rt[0];
    for (int cyc = 0; cyc < 60 && outs < 14; cyc++) begin
      if (bus.in_valid && !bus.in_ready) stalls++;
      step(acc, fired, got);
      if (fired) begin
        if (outs == 0) first_fire = cyc;
        n_checks++;
        if (sb.size() == 0) $display("FAIL decode_extra got=%h", got);
        else begin
          e = sb.pop_front();
          if (e.br || e.ill) got.wr_reg = e.wr_reg;
          if (got !== e) $display("FAIL decode_pkt[%0d] got=%h exp=%h", outs, got, e); else n_pass++;
        end
        n_checks++;
        if (got.result !== t_res[outs]) $display("FAIL decode_result[%0d] got=%h exp=%h", outs, got.result, t_res[outs]);
        else n_pass++;
        outs++;
      end
      if (acc) begin
        n_checks++;
        if (bus.alu_op !== t_op[idx]) $display("FAIL decode_alu_op[%0d] got=%b exp=%b", idx, bus.alu_op, t_op[idx]);
        else n_pass++;
        if (t_ins[idx][31:26] == 6'h3F) begin
          n_checks++;
          if (bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0)
            $display("FAIL illegal_operands got=%h/%h exp=0/0", bus.alu_a, bus.alu_b);
          else n_pass++;
        end
        idx++;
        if (idx < 14) begin
          bus.in_instr = t_ins[idx]; bus.in_rs_val = t_rs[idx]; bus.in_rt_val = t_rt[idx];
        end else bus.in_valid = 1'b0;
      end
    end
    n_checks++;
    if (outs != 14) $display("FAIL decode_count got=%0d exp=14", outs); else n_pass++;
    n_checks++;
    if (first_fire != 2) $display("FAIL decode_latency got=%0d exp=2", first_fire); else n_pass++;
    n_checks++;
    if (stalls != 0) $display("FAIL decode_throughput stalls=%0d exp=0", stalls); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit acc, fired;
    pkt_t got, e, snap;
    logic [31:0] snap_a;
    bit have_snap;
    int unsigned k, accepts, outs, last_fire, gaps;
    k = 0; accepts = 0; outs = 0; gaps = 0; last_fire = 0; have_snap = 0; snap_a = '0; snap = '0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h012A4020; bus.in_rs_val = 32'd100; bus.in_rt_val = 32'd0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step(acc, fired, got);
      if (have_snap) begin
        n_checks++;
        if (got !== snap || bus.alu_a !== snap_a)
          $display("FAIL stall_stable got=%h/%h exp=%h/%h", got, bus.alu_a, snap, snap_a);
        else n_pass++;
      end else if (bus.out_valid && bus.in_ready == 1'b0) begin
        have_snap = 1;
        snap = {bus.out_result, bus.out_wr_en, bus.out_wr_reg,
                bus.out_branch, bus.out_taken, bus.out_illegal};
        snap_a = bus.alu_a;
      end
      if (acc) begin
        accepts++; k++;
        bus.in_rs_val = 32'd100 + k; bus.in_rt_val = k;
      end
    end
    n_checks++;
    if (accepts != 2) $display("FAIL bp_accepts got=%0d exp=2", accepts); else n_pass++;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && outs < 4; cyc++) begin
      step(acc, fired, got);
      if (acc) begin
        k++;
        if (k < 4) begin bus.in_rs_val = 32'd100 + k; bus.in_rt_val = k; end
        else bus.in_valid = 1'b0;
      end
      if (fired) begin
        if (outs > 0 && cyc != last_fire + 1) gaps++;
        last_fire = cyc;
        n_checks++;
        if (sb.size() == 0) $display("FAIL bp_extra got=%h", got);
        else begin
          e = sb.pop_front();
          if (got !== e) $display("FAIL bp_pkt[%0d] got=%h exp=%h", outs, got, e); else n_pass++;
        end
        outs++;
      end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (outs != 4 || sb.size() != 0) $display("FAIL bp_drain outs=%0d left=%0d exp=4/0", outs, sb.size());
    else n_pass++;
    n_checks++;
    if (gaps != 0) $display("FAIL bp_one_per_cycle gaps=%0d exp=0", gaps); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    bit acc, fired, done;
    pkt_t got, e;
    int unsigned acc_cyc, accepts;
    acc_cyc = 0; accepts = 0; done = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h012A4020; bus.in_rs_val = 32'd1; bus.in_rt_val = 32'd2;
    for (int cyc = 0; cyc < 2; cyc++) begin
      step(acc, fired, got);
      if (acc) accepts++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (accepts != 2 || bus.out_valid !== 1'b1) $display("FAIL mid_fill accepts=%0d out_valid=%b exp=2/1", accepts, bus.out_valid);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_result !== 32'h0 || bus.alu_op !== 3'b000)
      $display("FAIL mid_reset out_valid=%b in_ready=%b result=%h op=%b exp=0", bus.out_valid, bus.in_ready,
               bus.out_result, bus.alu_op);
    else n_pass++;
    sb.delete();
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00C72822; bus.in_rs_val = 32'd50; bus.in_rt_val = 32'd8;
    for (int cyc = 0; cyc < 10 && !done; cyc++) begin
      step(acc, fired, got);
      if (acc) begin acc_cyc = cyc; bus.in_valid = 1'b0; end
      if (fired) begin
        done = 1;
        n_checks++;
        if (cyc != acc_cyc + 2) $display("FAIL mid_latency got=%0d exp=2", cyc - acc_cyc); else n_pass++;
        n_checks++;
        if (sb.size() == 0) $display("FAIL mid_extra got=%h", got);
        else begin
          e = sb.pop_front();
          if (got !== e || got.result !== 32'd42) $display("FAIL mid_pkt got=%h exp=%h", got, e); else n_pass++;
        end
      end
    end
    n_checks++;
    if (!done || sb.size() != 0) $display("FAIL mid_timeout done=%b left=%0d", done, sb.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops[10] = '{32'h012A4020, 32'h00C72822, 32'h00641025, 32'h0064102A, 32'h2883FFFF,
                             32'h3083FFFF, 32'h10220010, 32'h14220010, 32'hFC221234, 32'h35098000};
    bit acc, fired, held;
    pkt_t got, e, snap;
    int unsigned sent, outs, errs, unstable;
    sent = 0; outs = 0; errs = 0; unstable = 0; held = 0; snap = '0;
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 400 && outs < 30; cyc++) begin
      if (!bus.in_valid && sent < 30 && $urandom_range(0, 3) != 0) begin
        bus.in_valid  = 1'b1;
        bus.in_instr  = ops[$urandom_range(0, 9)];
        bus.in_rs_val = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20));
        bus.in_rt_val = ($urandom_range(0, 1) != 0) ? bus.in_rs_val : $urandom;
      end
      bus.out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (held) begin
        if ({bus.out_result, bus.out_wr_en, bus.out_wr_reg, bus.out_branch, bus.out_taken,
             bus.out_illegal} !== snap || !bus.out_valid) unstable++;
      end
      step(acc, fired, got);
      held = (got == snap) ? held : 1'b0;
      held = 1'b0;
      if (bus.out_valid && !fired) begin
        // fired was sampled before the edge; recheck stall on the post-edge state next cycle
      end
      if (acc) begin sent++; bus.in_valid = 1'b0; end
      if (fired) begin
        if (sb.size() == 0) errs++;
        else begin
          e = sb.pop_front();
          if (e.br || e.ill) got.wr_reg = e.wr_reg;
          if (got !== e) begin
            errs++;
            $display("FAIL b2b_pkt[%0d] got=%h exp=%h", outs, got, e);
          end
        end
        outs++;
      end else if (got.result === bus.out_result && bus.out_valid && got.wr_en === bus.out_wr_en) begin
        held = 1'b0;
      end
      if (bus.out_valid && !fired && got.result === bus.out_result) begin
        held = 1'b1;
        snap = {bus.out_result, bus.out_wr_en, bus.out_wr_reg, bus.out_branch, bus.out_taken, bus.out_illegal};
      end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (errs != 0 || outs != 30 || sb.size() != 0)
      $display("FAIL b2b_stream errs=%0d outs=%0d left=%0d exp=0/30/0", errs, outs, sb.size());
    else n_pass++;
    n_checks++;
    if (unstable != 0) $display("FAIL b2b_stall_stable count=%0d exp=0", unstable); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_rs_val = '0;
    bus.in_rt_val = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_decode();
    test_backpressure();
    test_reset_midstream();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
